// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer
// Sample-loop sequencer for one pid_controller. It generates the sample tick
// and fetches a sensor word from the ADC over a req/ack handshake. It presents
// the word to the PID datapath and captures the PID result after PID_LAT clocks.
// It then pulses the PID history enable and forwards the result to the PWM stage.
//
// Ports:
//   clk_in_i       system clock
//   reset_i        asynchronous active-high reset
//   en_i           loop enable
//   period_i       sample period minus one, in clocks
//   man_control_i  manual override select
//   man_duty_i     manual output value
//   adc_req_o      conversion request (high while waiting for ack)
//   adc_ack_i      conversion done, adc_data_i valid
//   adc_data_i     sensor word
//   sens_data_o    sensor word to PID
//   sens_rdy_o     sensor-ready level to PID (PID_LAT clocks per sample)
//   pid_i          PID result
//   clk_en_o       one-cycle PID history enable per completed sample
//   ctrl_o         output value to PWM
//   ctrl_vld_o     one-cycle strobe when ctrl_o is updated
//   fault_o        sticky ADC-timeout flag
//   overrun_o      sticky dropped-tick flag
//   sample_cnt_o   completed samples, modulo 2^16
module pid_loop_sequencer #(
  parameter int unsigned PID_LAT   = 3,
  parameter int unsigned ADC_TO    = 255,
  parameter logic [15:0] SAFE_DUTY = 16'h0000
) (
  input  logic        clk_in_i,
  input  logic        reset_i,
  input  logic        en_i,
  input  logic [15:0] period_i,
  input  logic        man_control_i,
  input  logic [15:0] man_duty_i,
  output logic        adc_req_o,
  input  logic        adc_ack_i,
  input  logic [15:0] adc_data_i,
  output logic [15:0] sens_data_o,
  output logic        sens_rdy_o,
  input  logic [15:0] pid_i,
  output logic        clk_en_o,
  output logic [15:0] ctrl_o,
  output logic        ctrl_vld_o,
  output logic        fault_o,
  output logic        overrun_o,
  output logic [15:0] sample_cnt_o
);

  localparam int unsigned TO_W  = $clog2(ADC_TO + 1);
  localparam int unsigned LAT_W = $clog2(PID_LAT + 1);
  // Last REQ clock before timing out, and last PRESENT count before capture.
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ADC_TO - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PID_LAT - 2);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WAIT    = 3'd1,
    S_REQ     = 3'd2,
    S_PRESENT = 3'd3,
    S_CAPTURE = 3'd4,
    S_FAULT   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [15:0]       tick_cnt_q, tick_cnt_d;
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic              adc_req_q, adc_req_d;
  logic [15:0]       sens_data_q, sens_data_d;
  logic              sens_rdy_q, sens_rdy_d;
  logic [15:0]       pid_q, pid_d;
  logic              clk_en_q, clk_en_d;
  logic [15:0]       ctrl_q, ctrl_d;
  logic              ctrl_vld_q, ctrl_vld_d;
  logic              fault_q, fault_d;
  logic              overrun_q, overrun_d;
  logic [15:0]       sample_cnt_q, sample_cnt_d;
  logic              tick_s;

  // Sample-period counter: counts 0..period_i while enabled, ticks on the last count.
  always_comb begin
    tick_s     = 1'b0;
    tick_cnt_d = tick_cnt_q;
    if (!en_i) begin
      tick_cnt_d = 16'd0;
    end else if (tick_cnt_q == period_i) begin
      tick_s     = 1'b1;
      tick_cnt_d = 16'd0;
    end else begin
      tick_cnt_d = tick_cnt_q + 16'd1;
    end
  end

  // Sequencer next state and registered-output next values.
  always_comb begin
    state_d      = state_q;
    to_cnt_d     = to_cnt_q;
    lat_cnt_d    = lat_cnt_q;
    adc_req_d    = adc_req_q;
    sens_data_d  = sens_data_q;
    sens_rdy_d   = sens_rdy_q;
    pid_d        = pid_q;
    clk_en_d     = 1'b0;
    ctrl_d       = ctrl_q;
    ctrl_vld_d   = 1'b0;
    fault_d      = fault_q;
    overrun_d    = overrun_q;
    sample_cnt_d = sample_cnt_q;

    // A tick that finds the loop busy is dropped and remembered.
    if (!en_i) begin
      overrun_d = 1'b0;
    end else if (tick_s && (state_q != S_WAIT)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end

    case (state_q)
      S_IDLE: begin
        if (en_i) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (tick_s) begin
          state_d   = S_REQ;
          adc_req_d = 1'b1;
          to_cnt_d  = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_REQ: begin
        if (adc_ack_i) begin
          sens_data_d = adc_data_i;
          sens_rdy_d  = 1'b1;
          adc_req_d   = 1'b0;
          lat_cnt_d   = '0;
          state_d     = S_PRESENT;
        end else if (to_cnt_q == TO_LAST) begin
          adc_req_d = 1'b0;
          fault_d   = 1'b1;
          ctrl_d    = SAFE_DUTY;
          state_d   = S_FAULT;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      S_PRESENT: begin
        // sens_rdy stays high through this state and drops when CAPTURE retires.
        if (lat_cnt_q == LAT_LAST) begin
          pid_d   = pid_i;
          state_d = S_CAPTURE;
        end else begin
          lat_cnt_d = lat_cnt_q + LAT_W'(1);
        end
      end
      S_CAPTURE: begin
        sens_rdy_d   = 1'b0;
        clk_en_d     = 1'b1;
        sample_cnt_d = sample_cnt_q + 16'd1;
        state_d      = S_WAIT;
        if (!man_control_i) begin
          ctrl_d     = pid_q;
          ctrl_vld_d = 1'b1;
        end else begin
          ctrl_d = ctrl_q;
        end
      end
      S_FAULT: begin
        adc_req_d  = 1'b0;
        sens_rdy_d = 1'b0;
        ctrl_d     = SAFE_DUTY;
        if (!en_i) begin
          fault_d = 1'b0;
          state_d = S_IDLE;
        end else begin
          fault_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Manual override tracks man_duty_i every clock; FAULT (current or entering) wins.
    if (man_control_i && en_i && (state_q != S_FAULT) && (state_d != S_FAULT)) begin
      ctrl_d     = man_duty_i;
      ctrl_vld_d = (man_duty_i != ctrl_q);
    end else begin
      ctrl_d = ctrl_d;
    end

    // Disable abandons any partial sample but keeps ctrl and the sample count.
    if (!en_i && (state_q != S_FAULT)) begin
      state_d      = S_IDLE;
      adc_req_d    = 1'b0;
      sens_rdy_d   = 1'b0;
      clk_en_d     = 1'b0;
      ctrl_d       = ctrl_q;
      ctrl_vld_d   = 1'b0;
      sample_cnt_d = sample_cnt_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_in_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= 16'd0;
      to_cnt_q     <= '0;
      lat_cnt_q    <= '0;
      adc_req_q    <= 1'b0;
      sens_data_q  <= 16'd0;
      sens_rdy_q   <= 1'b0;
      pid_q        <= 16'd0;
      clk_en_q     <= 1'b0;
      ctrl_q       <= 16'd0;
      ctrl_vld_q   <= 1'b0;
      fault_q      <= 1'b0;
      overrun_q    <= 1'b0;
      sample_cnt_q <= 16'd0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      to_cnt_q     <= to_cnt_d;
      lat_cnt_q    <= lat_cnt_d;
      adc_req_q    <= adc_req_d;
      sens_data_q  <= sens_data_d;
      sens_rdy_q   <= sens_rdy_d;
      pid_q        <= pid_d;
      clk_en_q     <= clk_en_d;
      ctrl_q       <= ctrl_d;
      ctrl_vld_q   <= ctrl_vld_d;
      fault_q      <= fault_d;
      overrun_q    <= overrun_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign adc_req_o    = adc_req_q;
  assign sens_data_o  = sens_data_q;
  assign sens_rdy_o   = sens_rdy_q;
  assign clk_en_o     = clk_en_q;
  assign ctrl_o       = ctrl_q;
  assign ctrl_vld_o   = ctrl_vld_q;
  assign fault_o      = fault_q;
  assign overrun_o    = overrun_q;
  assign sample_cnt_o = sample_cnt_q;

endmodule

// File: tb/tb_pid_loop_sequencer.sv
// Self-checking bench for pid_loop_sequencer: ADC responder and PID model
// drive the DUT; expected ctrl values are queued at ADC-ack time and
// compared when ctrl_vld_o strobes.
module tb_pid_loop_sequencer;
  localparam int PID_LAT = 3;

  logic        clk, rst, en, man, ack;
  logic [15:0] period, man_duty, adc_data, pid;
  logic        adc_req_o, sens_rdy_o, clk_en_o, ctrl_vld_o, fault_o, overrun_o;
  logic [15:0] sens_data_o, ctrl_o, sample_cnt_o;

  pid_loop_sequencer dut (
    .clk_in_i(clk), .reset_i(rst), .en_i(en), .period_i(period),
    .man_control_i(man), .man_duty_i(man_duty),
    .adc_req_o(adc_req_o), .adc_ack_i(ack), .adc_data_i(adc_data),
    .sens_data_o(sens_data_o), .sens_rdy_o(sens_rdy_o), .pid_i(pid),
    .clk_en_o(clk_en_o), .ctrl_o(ctrl_o), .ctrl_vld_o(ctrl_vld_o),
    .fault_o(fault_o), .overrun_o(overrun_o), .sample_cnt_o(sample_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Model state
  logic [15:0] sb[$];        // expected ctrl values (PID mode samples)
  int          ack_q[$];     // ack edge of every accepted, uncaptured sample
  logic [15:0] exp_cnt = 16'd0;
  logic [15:0] next_word = 16'h0100;
  logic [15:0] pid_ofs = 16'h1134;  // 0x0100 + 0x1134 = 0x1234
  logic [15:0] last_ctrl = 16'd0;
  int          ack_dly = 2;
  bit          ack_en = 1'b1;
  bit          busy = 1'b0;
  bit          req_prev = 1'b0;
  bit          chk_period = 1'b0;
  int          last_vld = -1;
  int          n_clken = 0;
  int          req_age = 0;
  int          rdy_cnt = 0;

  // Monitor + ADC responder + PID model, all at the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        ack = 1'b0;
        req_age = 0;
        rdy_cnt = 0;
        req_prev = 1'b0;
      end else begin
        if (adc_req_o && !req_prev) begin
          check_eq("req_while_busy", busy, 0);
          busy = 1'b1;
        end
        req_prev = adc_req_o;
        if (fault_o) busy = 1'b0;
        if (clk_en_o) begin
          busy = 1'b0;
          n_clken++;
          check_eq("clken_pending", ack_q.size() > 0, 1);
          if (ack_q.size() > 0) check_eq("clken_latency", cyc - ack_q.pop_front(), PID_LAT);
        end
        if (ctrl_vld_o && !man) begin
          check_eq("vld_pending", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            last_ctrl = sb.pop_front();
            check_eq("ctrl_value", ctrl_o, last_ctrl);
          end
          if (chk_period && last_vld >= 0) check_eq("vld_period", cyc - last_vld, period + 1);
          last_vld = cyc;
        end
        // PID model: result valid only after PID_LAT-1 clocks of sens_rdy.
        rdy_cnt = sens_rdy_o ? rdy_cnt + 1 : 0;
        pid = (rdy_cnt >= PID_LAT - 1) ? sens_data_o + pid_ofs : 16'hDEAD;
        // ADC: ack ack_dly clocks after the request rises.
        if (adc_req_o && ack_en) begin
          req_age++;
          if (req_age == ack_dly) begin
            ack = 1'b1;
            adc_data = next_word;
            ack_q.push_back(cyc + 1);
            if (!man) sb.push_back(next_word + pid_ofs);
            exp_cnt = exp_cnt + 16'd1;
            next_word = next_word + 16'd1;
          end else begin
            ack = 1'b0;
          end
        end else begin
          req_age = 0;
          ack = 1'b0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_clken(input int n, input int budget);
    int target;
    target = n_clken + n;
    for (int i = 0; i < budget && n_clken < target; i++) step(1);
    check_eq("samples_done", n_clken, target);
  endtask

  task automatic flush_model();
    exp_cnt = exp_cnt - 16'(ack_q.size());
    sb.delete();
    ack_q.delete();
    busy = 1'b0;
    last_vld = -1;
  endtask

  task automatic disable_en();
    en = 1'b0;
    step(1);
    flush_model();
  endtask

  task automatic check_zero(input string pfx);
    check_eq({pfx, "_ctrl"}, ctrl_o, 0);
    check_eq({pfx, "_vld"}, ctrl_vld_o, 0);
    check_eq({pfx, "_req"}, adc_req_o, 0);
    check_eq({pfx, "_rdy"}, sens_rdy_o, 0);
    check_eq({pfx, "_sdata"}, sens_data_o, 0);
    check_eq({pfx, "_clken"}, clk_en_o, 0);
    check_eq({pfx, "_fault"}, fault_o, 0);
    check_eq({pfx, "_ovr"}, overrun_o, 0);
    check_eq({pfx, "_cnt"}, sample_cnt_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; man = 1'b0; man_duty = 16'd0; period = 16'd99;
    ack = 1'b0; adc_data = 16'd0; pid = 16'd0;
    step(3);
    check_zero("rst");
    rst = 1'b0;
    step(2);
    check_zero("idle");

    // Normal loop: period 100, ack delay 2, PID returns 0x1234 for the first word.
    chk_period = 1'b1;
    en = 1'b1;
    wait_clken(5, 800);
    chk_period = 1'b0;
    check_eq("norm_cnt", sample_cnt_o, exp_cnt);
    check_eq("norm_ctrl", ctrl_o, 16'h1238);
    check_eq("norm_ovr", overrun_o, 0);
    check_eq("norm_fault", fault_o, 0);

    // Disable mid-PRESENT: sample discarded, ctrl and count held.
    for (int i = 0; i < 200 && !sens_rdy_o; i++) step(1);
    check_eq("md_rdy_seen", sens_rdy_o, 1);
    disable_en();
    check_eq("md_rdy", sens_rdy_o, 0);
    check_eq("md_ctrl", ctrl_o, last_ctrl);
    check_eq("md_cnt", sample_cnt_o, exp_cnt);
    check_eq("md_clken", clk_en_o, 0);
    en = 1'b1;
    wait_clken(1, 300);

    // Manual override.
    man_duty = 16'h0800;
    man = 1'b1;
    step(1);
    check_eq("man_ctrl", ctrl_o, 16'h0800);
    check_eq("man_vld", ctrl_vld_o, 1);
    step(1);
    check_eq("man_vld_once", ctrl_vld_o, 0);
    wait_clken(2, 300);
    check_eq("man_hold", ctrl_o, 16'h0800);
    check_eq("man_cnt", sample_cnt_o, exp_cnt);
    man_duty = 16'h0900;
    step(1);
    check_eq("man_ctrl2", ctrl_o, 16'h0900);
    check_eq("man_vld2", ctrl_vld_o, 1);
    man = 1'b0;
    wait_clken(1, 300);
    wait_clken(1, 300);

    // ADC timeout.
    begin
      int t0;
      ack_en = 1'b0;
      for (int i = 0; i < 200 && !adc_req_o; i++) step(1);
      check_eq("to_req_seen", adc_req_o, 1);
      t0 = cyc;
      for (int i = 0; i < 400 && !fault_o; i++) step(1);
      check_eq("to_fault", fault_o, 1);
      check_eq("to_clocks", cyc - t0, 255);
      check_eq("to_ctrl", ctrl_o, 16'h0000);
      check_eq("to_req", adc_req_o, 0);
      check_eq("to_rdy", sens_rdy_o, 0);
      step(20);
      check_eq("to_sticky", fault_o, 1);
      disable_en();
      check_eq("to_clear", fault_o, 0);
      check_eq("to_ovr_clear", overrun_o, 0);
      ack_en = 1'b1;
      en = 1'b1;
      wait_clken(2, 400);
      check_eq("to_resume", fault_o, 0);
      check_eq("to_cnt", sample_cnt_o, exp_cnt);
    end

    // Overrun: period 3 clocks, ack delay 5.
    disable_en();
    period = 16'd2;
    ack_dly = 5;
    en = 1'b1;
    wait_clken(3, 200);
    check_eq("ovr_set", overrun_o, 1);
    check_eq("ovr_cnt", sample_cnt_o, exp_cnt);
    disable_en();
    check_eq("ovr_clear", overrun_o, 0);
    period = 16'd99;
    ack_dly = 2;

    // Reset in REQ: all outputs zero without a clock edge.
    en = 1'b1;
    for (int i = 0; i < 200 && !adc_req_o; i++) step(1);
    check_eq("rq_req_seen", adc_req_o, 1);
    rst = 1'b1;
    #1;
    check_zero("rq");
    flush_model();
    exp_cnt = 16'd0;
    en = 1'b0;
    step(2);
    rst = 1'b0;
    step(1);

    // Sample counter wrap.
    force dut.sample_cnt_q = 16'hFFFE;
    step(1);
    release dut.sample_cnt_q;
    exp_cnt = 16'hFFFE;
    step(1);
    check_eq("wrap_preset", sample_cnt_o, 16'hFFFE);
    en = 1'b1;
    wait_clken(1, 300);
    check_eq("wrap_ffff", sample_cnt_o, 16'hFFFF);
    wait_clken(1, 300);
    check_eq("wrap_zero", sample_cnt_o, 16'h0000);
    check_eq("wrap_model", sample_cnt_o, exp_cnt);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
